tone_sequencer: RTL and testbench

//   Sequencer driving the en/incr inputs of the sine generator. Plays a programmed table of

---
 rtl/tone_sequencer.sv | 136 +++++++++++++
 tb/tb_tone_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - plays a table of {incr,dur,last} tones into sinegen en/incr
// Optional feature macro: TONE_SEQ_LOOP_EN adds a `loop` input for continuous replay.
module tone_sequencer #(
  parameter int D_WIDTH    = 8,
  parameter int STEPS      = 16,
  parameter int DUR_WIDTH  = 16,
  parameter int GAP_CYCLES = 4,
  localparam int AW        = $clog2(STEPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [D_WIDTH-1:0]   cfg_incr,
  input  logic [DUR_WIDTH-1:0] cfg_dur,
  input  logic                 cfg_last,
`ifdef TONE_SEQ_LOOP_EN
  input  logic                 loop,
`endif
  input  logic                 start,
  input  logic                 stop,
  output logic                 gen_en,
  output logic [D_WIDTH-1:0]   gen_incr,
  output logic [AW-1:0]        step_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int CW = (DUR_WIDTH > GW) ? DUR_WIDTH : GW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t state, state_nx;

  logic [D_WIDTH-1:0]   tbl_incr [STEPS];
  logic [DUR_WIDTH-1:0] tbl_dur  [STEPS];
  logic [STEPS-1:0]     tbl_last;

  logic [CW-1:0] cnt;
  logic          step_end;
  logic          last_or_top;
  logic          seq_finish;
  logic          loop_now;
  logic [AW-1:0] next_idx;

`ifdef TONE_SEQ_LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  // The table is frozen while busy, so the wrap decision can be re-derived in GAP.
  assign last_or_top = tbl_last[step_idx] || (step_idx == AW'(STEPS - 1));
  assign next_idx    = last_or_top ? '0 : step_idx + AW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STEPS; i++) begin
        tbl_incr[i] <= '0;
        tbl_dur[i]  <= '0;
      end
      tbl_last <= '0;
    end else if (cfg_we && !busy) begin
      tbl_incr[cfg_addr] <= cfg_incr;
      tbl_dur[cfg_addr]  <= cfg_dur;
      tbl_last[cfg_addr] <= cfg_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    step_end = 1'b0;
    case (state)
      S_IDLE: if (start && !stop) state_nx = S_LOAD;
      S_LOAD: begin
        if (stop)                         state_nx = S_IDLE;
        else if (tbl_dur[step_idx] == '0) step_end = 1'b1;
        else                              state_nx = S_PLAY;
      end
      S_PLAY: begin
        if (stop)                state_nx = S_IDLE;
        else if (cnt == CW'(1))  step_end = 1'b1;
      end
      S_GAP: begin
        if (stop)                state_nx = S_IDLE;
        else if (cnt == CW'(1))  state_nx = S_LOAD;
      end
      default: state_nx = S_IDLE;
    endcase
    seq_finish = step_end && last_or_top && !loop_now;
    if (step_end) begin
      if (seq_finish)           state_nx = S_IDLE;
      else if (GAP_CYCLES == 0) state_nx = S_LOAD;
      else                      state_nx = S_GAP;
    end
  end

  always_comb begin
    gen_en = (state == S_PLAY);
    busy   = (state != S_IDLE);
  end

  // gen_incr is only ever reloaded, never cleared, so sinegen phase freezes between tones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      gen_incr <= '0;
      step_idx <= '0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done    <= seq_finish;
      cfg_err <= cfg_we && busy;
      if (state == S_IDLE && state_nx == S_LOAD)
        step_idx <= '0;
      else if (state != S_IDLE && state_nx == S_LOAD)
        step_idx <= next_idx;
      if (state == S_LOAD && !stop)
        gen_incr <= tbl_incr[step_idx];
      if (state_nx == S_GAP && state != S_GAP)
        cnt <= CW'(GAP_CYCLES);
      else if (state == S_LOAD && state_nx == S_PLAY)
        cnt <= CW'(tbl_dur[step_idx]);
      else if (state == S_PLAY || state == S_GAP)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - scoreboard bench for tone_sequencer (default parameters)
// Runs the loop scenario only when TONE_SEQ_LOOP_EN is defined.
module tb_tone_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_incr;
  logic [15:0] cfg_dur;
  logic       cfg_last;
  logic       start;
  logic       stop;
  logic       gen_en;
  logic [7:0] gen_incr;
  logic [3:0] step_idx;
  logic       busy;
  logic       done;
  logic       cfg_err;
`ifdef TONE_SEQ_LOOP_EN
  logic       loop;
`endif

  tone_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_incr (cfg_incr),
    .cfg_dur  (cfg_dur),
    .cfg_last (cfg_last),
`ifdef TONE_SEQ_LOOP_EN
    .loop     (loop),
`endif
    .start    (start),
    .stop     (stop),
    .gen_en   (gen_en),
    .gen_incr (gen_incr),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       en;
    logic [7:0] incr;
    logic [3:0] idx;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic b, input logic en, input logic [7:0] incr,
                      input logic [3:0] idx, input logic d, input logic err);
    exp_t e;
    e.busy = b; e.en = en; e.incr = incr; e.idx = idx; e.done = d; e.err = err;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("busy",     {31'd0, busy},     {31'd0, e.busy});
      check("gen_en",   {31'd0, gen_en},   {31'd0, e.en});
      check("gen_incr", {24'd0, gen_incr}, {24'd0, e.incr});
      check("step_idx", {28'd0, step_idx}, {28'd0, e.idx});
      check("done",     {31'd0, done},     {31'd0, e.done});
      check("cfg_err",  {31'd0, cfg_err},  {31'd0, e.err});
    end
  end

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [7:0] inc,
                             input logic [15:0] dur, input logic last);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_incr = inc; cfg_dur = dur; cfg_last = last;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Table {0: incr=2,dur=0; 1: incr=7,dur=5,last}: skip entry 0, gap, play entry 1.
  task automatic push_t3(input int upto, input logic [7:0] pincr,
                         input logic [3:0] pidx, input int err_at);
    for (int c = 0; c <= upto; c++) begin
      logic er;
      er = (c == err_at);
      if (c == 0)       push(0, 0, pincr, pidx, 0, er);
      else if (c == 1)  push(1, 0, pincr, 0, 0, er);
      else if (c <= 5)  push(1, 0, 8'd2, 0, 0, er);
      else if (c == 6)  push(1, 0, 8'd2, 1, 0, er);
      else if (c <= 11) push(1, 1, 8'd7, 1, 0, er);
      else if (c == 12) push(0, 0, 8'd7, 1, 1, er);
      else              push(0, 0, 8'd7, 1, 0, er);
    end
  endtask

  task automatic kick();
    @(posedge clk); #1;
    start = 1'b1;
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_incr = '0; cfg_dur = '0;
    cfg_last = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef TONE_SEQ_LOOP_EN
    loop = 1'b0;
`endif
    push(0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drain();

    // Two tones with a 4-cycle gap.
    write_entry(4'd0, 8'd4, 16'd3, 1'b0);
    write_entry(4'd1, 8'd9, 16'd2, 1'b1);
    kick();
    push(0, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 0, 0);
    for (int c = 2; c <= 4; c++) push(1, 1, 8'd4, 0, 0, 0);
    for (int c = 5; c <= 8; c++) push(1, 0, 8'd4, 0, 0, 0);
    push(1, 0, 8'd4, 1, 0, 0);
    push(1, 1, 8'd9, 1, 0, 0);
    push(1, 1, 8'd9, 1, 0, 0);
    push(0, 0, 8'd9, 1, 1, 0);
    push(0, 0, 8'd9, 1, 0, 0);
    @(posedge clk); #1 start = 1'b0;
    drain();

    // Zero-duration entry is skipped.
    write_entry(4'd0, 8'd2, 16'd0, 1'b0);
    write_entry(4'd1, 8'd7, 16'd5, 1'b1);
    kick();
    push_t3(13, 8'd9, 4'd1, -1);
    @(posedge clk); #1 start = 1'b0;
    drain();

    // Write and start during PLAY: write dropped with cfg_err, start ignored.
    kick();
    push_t3(13, 8'd7, 4'd1, 9);
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      start = (c == 8);
      cfg_we = (c == 8);
      cfg_addr = 4'd1; cfg_incr = 8'h55; cfg_dur = 16'd1; cfg_last = 1'b1;
    end
    cfg_we = 1'b0;
    drain();
    kick();
    push_t3(13, 8'd7, 4'd1, -1);
    @(posedge clk); #1 start = 1'b0;
    drain();

    // Stop on the second PLAY cycle, then start+stop together in IDLE.
    kick();
    push_t3(8, 8'd7, 4'd1, -1);
    push(0, 0, 8'd7, 1, 0, 0);
    push(0, 0, 8'd7, 1, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop = (c == 8);
    end
    drain();
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    for (int c = 0; c < 4; c++) push(0, 0, 8'd7, 1, 0, 0);
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    drain();

    // Reset mid-PLAY, then the cleared table runs all zero-length entries to STEPS-1.
    kick();
    push_t3(7, 8'd7, 4'd1, -1);
    push(0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 8) rst = 1'b0;
      if (c == 9) rst = 1'b1;
    end
    drain();
    kick();
    push(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      push(1, 0, 0, 4'(k), 0, 0);
      if (k < 15) for (int g = 0; g < 4; g++) push(1, 0, 0, 4'(k), 0, 0);
    end
    push(0, 0, 0, 4'd15, 1, 0);
    push(0, 0, 0, 4'd15, 0, 0);
    @(posedge clk); #1 start = 1'b0;
    drain();

`ifdef TONE_SEQ_LOOP_EN
    // Looping two-entry table; loop dropped during the second pass.
    write_entry(4'd0, 8'd3, 16'd1, 1'b0);
    write_entry(4'd1, 8'd5, 16'd1, 1'b1);
    @(posedge clk); #1;
    loop = 1'b1; start = 1'b1;
    push(0, 0, 0, 4'd15, 0, 0);
    push(1, 0, 0, 0, 0, 0);
    for (int c = 2; c <= 20; c++) begin
      int p;
      p = (c - 1) % 12;
      push(1, (p == 1 || p == 7), (p >= 1 && p <= 6) ? 8'd3 : 8'd5,
           (p < 6) ? 4'd0 : 4'd1, 0, 0);
    end
    push(0, 0, 8'd5, 4'd1, 1, 0);
    push(0, 0, 8'd5, 4'd1, 0, 0);
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 15) loop = 1'b0;
    end
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
